// File: rtl/motor_cmd_seq.sv
// motor_cmd_seq: direction-change sequencer (ramp-down, dead time, brake).
// Define MOTOR_CMD_RAMP_EN for prescaled duty ramping; else duty steps.
module motor_cmd_seq #(
  parameter int DUTY_W      = 8,
  parameter int DEAD_CYCLES = 1000,
  parameter int RAMP_DIV    = 100,
  parameter int RAMP_STEP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              brake_req,
  output logic [1:0]        mode,
  output logic [DUTY_W-1:0] duty,
  output logic              busy
);

  typedef enum logic [1:0] {
    RUN, RAMPDN, DEAD, BRAKE
  } state_t;

  localparam int DW = $clog2(DEAD_CYCLES) + 1;

  state_t            state, state_d;
  logic [1:0]        cur_dir, cur_dir_d;
  logic [1:0]        nxt_dir, nxt_dir_d;
  logic [1:0]        mode_d;
  logic [DUTY_W-1:0] target, target_d;
  logic [DUTY_W-1:0] nxt_target, nxt_target_d;
  logic [DUTY_W-1:0] duty_d, eff_duty, ramp_duty;
  logic [DW-1:0]     dead_cnt, dead_cnt_d;
  logic              accept, rampdn_done;

  assign cmd_ready = (state == RUN) && !brake_req;
  assign busy      = (state != RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign eff_duty  = (cmd_dir == 2'b00 || cmd_dir == 2'b11)
                   ? '0 : cmd_duty;

`ifdef MOTOR_CMD_RAMP_EN
  localparam int PW = $clog2(RAMP_DIV) + 1;

  logic [PW-1:0]     presc, presc_d;
  logic [DUTY_W-1:0] gap;
  logic              wrap, up;

  assign wrap = (presc == PW'(RAMP_DIV - 1));
  assign up   = (target > duty);
  assign gap  = up ? target - duty : duty - target;

  // Clamp the last step so duty lands exactly on target.
  always_comb begin
    ramp_duty = duty;
    if (wrap) begin
      if (32'(gap) <= 32'(RAMP_STEP))
        ramp_duty = target;
      else if (up)
        ramp_duty = duty + DUTY_W'(RAMP_STEP);
      else
        ramp_duty = duty - DUTY_W'(RAMP_STEP);
    end
  end

  assign rampdn_done = (duty == '0);
`else
  logic unused_cfg;

  assign unused_cfg  = ^{RAMP_DIV[0], RAMP_STEP[0]};
  assign ramp_duty   = target;
  assign rampdn_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      RUN:
        if (accept && cmd_dir != cur_dir)
          state_d = RAMPDN;
      RAMPDN:
        if (rampdn_done) state_d = DEAD;
      DEAD:
        if (dead_cnt == '0) state_d = RUN;
      BRAKE:
        state_d = DEAD;
      default:
        state_d = RUN;
    endcase
    if (brake_req) state_d = BRAKE;
  end

  always_comb begin
    cur_dir_d    = cur_dir;
    nxt_dir_d    = nxt_dir;
    target_d     = target;
    nxt_target_d = nxt_target;
    dead_cnt_d   = dead_cnt;
    duty_d       = '0;
    mode_d       = 2'b00;
`ifdef MOTOR_CMD_RAMP_EN
    presc_d      = '0;
    if (state == RUN || state == RAMPDN)
      presc_d = wrap ? '0 : presc + PW'(1);
`endif
    unique case (state)
      RUN: begin
        duty_d = ramp_duty;
        if (accept) begin
          if (cmd_dir == cur_dir) begin
            target_d = eff_duty;
          end else begin
            nxt_dir_d    = cmd_dir;
            nxt_target_d = eff_duty;
            target_d     = '0;
          end
        end
      end
      RAMPDN: begin
`ifdef MOTOR_CMD_RAMP_EN
        duty_d = ramp_duty;
`endif
      end
      DEAD: begin
        if (dead_cnt != '0) begin
          dead_cnt_d = dead_cnt - DW'(1);
        end else begin
          cur_dir_d = nxt_dir;
          target_d  = nxt_target;
        end
      end
      BRAKE: begin
        nxt_dir_d    = 2'b00;
        nxt_target_d = '0;
      end
      default: ;
    endcase
    if (state_d == DEAD && state != DEAD)
      dead_cnt_d = DW'(DEAD_CYCLES - 1);
    // Brake wins over any command or transition in flight.
    if (brake_req) begin
      cur_dir_d    = cur_dir;
      nxt_dir_d    = 2'b00;
      nxt_target_d = '0;
      target_d     = '0;
      duty_d       = '0;
`ifdef MOTOR_CMD_RAMP_EN
      presc_d      = '0;
`endif
    end
    unique case (state_d)
      RUN, RAMPDN: mode_d = cur_dir_d;
      BRAKE:       mode_d = 2'b11;
      default:     mode_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_dir    <= 2'b00;
      nxt_dir    <= 2'b00;
      target     <= '0;
      nxt_target <= '0;
      dead_cnt   <= '0;
      mode       <= 2'b00;
      duty       <= '0;
`ifdef MOTOR_CMD_RAMP_EN
      presc      <= '0;
`endif
    end else begin
      cur_dir    <= cur_dir_d;
      nxt_dir    <= nxt_dir_d;
      target     <= target_d;
      nxt_target <= nxt_target_d;
      dead_cnt   <= dead_cnt_d;
      mode       <= mode_d;
      duty       <= duty_d;
`ifdef MOTOR_CMD_RAMP_EN
      presc      <= presc_d;
`endif
    end
  end

endmodule

// File: tb/tb_motor_cmd_seq.sv
// tb_motor_cmd_seq: directed checks of ramp, dead time and brake sequencing.
// Expected tables follow MOTOR_CMD_RAMP_EN so either build is checked.
module tb_motor_cmd_seq;

  localparam int DUTY_W      = 8;
  localparam int DEAD_CYCLES = 4;
  localparam int RAMP_DIV    = 2;
  localparam int RAMP_STEP   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_dir = 2'b00;
  logic [7:0]  cmd_duty = 8'd0;
  logic        brake_req = 1'b0;
  logic [1:0]  mode;
  logic [7:0]  duty;
  logic        busy;

  int total = 0;
  int bad = 0;

  motor_cmd_seq #(
    .DUTY_W(DUTY_W),
    .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_DIV(RAMP_DIV),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir),
    .cmd_duty(cmd_duty),
    .brake_req(brake_req),
    .mode(mode),
    .duty(duty),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input int b, input int m, input int d);
    return {b[0], m[1:0], d[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++;
    if ({busy, mode, duty} !== 11'h000) begin
      bad++;
      $display("FAIL reset_out got %h want %h", {busy, mode, duty}, 11'h000);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_forward();
    logic [10:0] exp [$];
`ifdef MOTOR_CMD_RAMP_EN
    exp = '{pk(1,0,0), pk(1,0,0), pk(1,0,0), pk(1,0,0), pk(1,0,0),
            pk(0,2,0), pk(0,2,0), pk(0,2,10), pk(0,2,10), pk(0,2,20),
            pk(0,2,20), pk(0,2,30), pk(0,2,30), pk(0,2,35)};
`else
    exp = '{pk(1,0,0), pk(1,0,0), pk(1,0,0), pk(1,0,0), pk(1,0,0),
            pk(0,2,0), pk(0,2,35)};
`endif
    cmd_dir = 2'b10;
    cmd_duty = 8'd35;
    cmd_valid = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL fwd_ready got %b want 1", cmd_ready);
    end
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      cmd_valid = 1'b0;
      total++;
      if ({busy, mode, duty} !== exp[i]) begin
        bad++;
        $display("FAIL fwd[%0d] got %h want %h", i, {busy, mode, duty}, exp[i]);
      end
    end
  endtask

  task automatic test_reversal();
    logic [10:0] exp [$];
`ifdef MOTOR_CMD_RAMP_EN
    exp = '{pk(1,2,35), pk(1,2,25), pk(1,2,25), pk(1,2,15), pk(1,2,15),
            pk(1,2,5), pk(1,2,5), pk(1,2,0), pk(1,0,0), pk(1,0,0),
            pk(1,0,0), pk(1,0,0), pk(0,1,0), pk(0,1,0), pk(0,1,10),
            pk(0,1,10), pk(0,1,20), pk(0,1,20), pk(0,1,30), pk(0,1,30),
            pk(0,1,40), pk(0,1,40), pk(0,1,50)};
`else
    exp = '{pk(1,2,35), pk(1,0,0), pk(1,0,0), pk(1,0,0), pk(1,0,0),
            pk(0,1,0), pk(0,1,50)};
`endif
    cmd_dir = 2'b01;
    cmd_duty = 8'd50;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL rev_ready got %b want 0", cmd_ready);
    end
    total++;
    if ({busy, mode, duty} !== exp[0]) begin
      bad++;
      $display("FAIL rev[0] got %h want %h", {busy, mode, duty}, exp[0]);
    end
    for (int i = 1; i < exp.size(); i++) begin
      tick();
      total++;
      if ({busy, mode, duty} !== exp[i]) begin
        bad++;
        $display("FAIL rev[%0d] got %h want %h", i, {busy, mode, duty}, exp[i]);
      end
    end
  endtask

  task automatic test_same_dir();
    logic [10:0] exp [$];
`ifdef MOTOR_CMD_RAMP_EN
    exp = '{pk(0,1,50), pk(0,1,40), pk(0,1,40), pk(0,1,30), pk(0,1,30),
            pk(0,1,20), pk(0,1,20), pk(0,1,12), pk(0,1,12)};
`else
    exp = '{pk(0,1,50), pk(0,1,12), pk(0,1,12)};
`endif
    cmd_dir = 2'b01;
    cmd_duty = 8'd12;
    cmd_valid = 1'b1;
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      cmd_valid = 1'b0;
      total++;
      if ({busy, mode, duty} !== exp[i]) begin
        bad++;
        $display("FAIL same[%0d] got %h want %h", i, {busy, mode, duty}, exp[i]);
      end
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL same_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_brake_dead();
    int n;
    cmd_dir = 2'b10;
    cmd_duty = 8'd80;
    cmd_valid = 1'b1;
    n = 0;
    tick();
    cmd_valid = 1'b0;
    while (mode !== 2'b00 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (mode !== 2'b00) begin
      bad++;
      $display("FAIL brk_dead_wait got %b want 00", mode);
    end
    tick();
    brake_req = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL brk_ready got %b want 0", cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({busy, mode, duty} !== pk(1,3,0)) begin
        bad++;
        $display("FAIL brk_hold[%0d] got %h want %h", i, {busy, mode, duty}, pk(1,3,0));
      end
    end
    brake_req = 1'b0;
    for (int i = 0; i < DEAD_CYCLES; i++) begin
      tick();
      total++;
      if ({busy, mode, duty} !== pk(1,0,0)) begin
        bad++;
        $display("FAIL brk_dead[%0d] got %h want %h", i, {busy, mode, duty}, pk(1,0,0));
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({busy, mode, duty} !== pk(0,0,0)) begin
        bad++;
        $display("FAIL brk_coast[%0d] got %h want %h", i, {busy, mode, duty}, pk(0,0,0));
      end
    end
  endtask

  task automatic test_brake_priority();
    cmd_dir = 2'b10;
    cmd_duty = 8'd60;
    cmd_valid = 1'b1;
    brake_req = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL pri_ready got %b want 0", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    brake_req = 1'b0;
    total++;
    if ({busy, mode, duty} !== pk(1,3,0)) begin
      bad++;
      $display("FAIL pri_brake got %h want %h", {busy, mode, duty}, pk(1,3,0));
    end
    for (int i = 0; i < DEAD_CYCLES; i++) begin
      tick();
      total++;
      if ({busy, mode, duty} !== pk(1,0,0)) begin
        bad++;
        $display("FAIL pri_dead[%0d] got %h want %h", i, {busy, mode, duty}, pk(1,0,0));
      end
    end
    tick();
    total++;
    if ({busy, mode, duty} !== pk(0,0,0)) begin
      bad++;
      $display("FAIL pri_coast got %h want %h", {busy, mode, duty}, pk(0,0,0));
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [7:0] exp_duty;
`ifdef MOTOR_CMD_RAMP_EN
    exp_duty = 8'd20;
`else
    exp_duty = 8'd35;
`endif
    cmd_dir = 2'b10;
    cmd_duty = 8'd35;
    cmd_valid = 1'b1;
    n = 0;
    tick();
    cmd_valid = 1'b0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if ({busy, mode} !== 3'b010) begin
      bad++;
      $display("FAIL ar_run got %b want 010", {busy, mode});
    end
    repeat (4) tick();
    total++;
    if (duty !== exp_duty) begin
      bad++;
      $display("FAIL ar_duty got %0d want %0d", duty, exp_duty);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, mode, duty} !== 11'h000) begin
      bad++;
      $display("FAIL ar_out got %h want %h", {busy, mode, duty}, 11'h000);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ar_ready got %b want 1", cmd_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({busy, mode, duty} !== 11'h000) begin
      bad++;
      $display("FAIL ar_after got %h want %h", {busy, mode, duty}, 11'h000);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reversal();
    test_same_dir();
    test_brake_dead();
    test_brake_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
